// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register.
// Captures the main decoder's control bits, the decode-stage operands and the
// register specifiers, and presents them to EX one cycle later. Supports stall
// (hold), flush (bubble) and forces don't-care decoder controls to 0 on load.
// Also produces the combinational load-use hazard flag for IF/ID.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   stall, flush      hold all state / load a bubble (flush wins)
//   id_valid          decode stage holds a real instruction
//   id_* controls     reg_dst, alu_src, mem_to_reg, reg_write, mem_read,
//                     mem_write, branch (1 bit each), alu_op (2 bits)
//   id_* data         pc_plus4, rs_data, rt_data, imm_ext (DATA_W)
//   id_rs/rt/rd       register specifiers (REG_ADDR_W), id_funct (6)
//   ex_*, ex_valid    registered copies of the above
//   load_use_hazard   stall request: the load in EX writes a register ID reads
module id_ex_pipeline_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic                  id_reg_dst,
  input  logic                  id_alu_src,
  input  logic                  id_mem_to_reg,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_branch,
  input  logic [1:0]            id_alu_op,
  input  logic [DATA_W-1:0]     id_pc_plus4,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm_ext,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [5:0]            id_funct,
  output logic                  ex_valid,
  output logic                  ex_reg_dst,
  output logic                  ex_alu_src,
  output logic                  ex_mem_to_reg,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_branch,
  output logic [1:0]            ex_alu_op,
  output logic [DATA_W-1:0]     ex_pc_plus4,
  output logic [DATA_W-1:0]     ex_rs_data,
  output logic [DATA_W-1:0]     ex_rt_data,
  output logic [DATA_W-1:0]     ex_imm_ext,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [5:0]            ex_funct,
  output logic                  load_use_hazard
);

  typedef struct packed {
    logic                  valid;
    logic                  regDst;
    logic                  aluSrc;
    logic                  memToReg;
    logic                  regWrite;
    logic                  memRead;
    logic                  memWrite;
    logic                  branch;
    logic [1:0]            aluOp;
    logic [DATA_W-1:0]     pcPlus4;
    logic [DATA_W-1:0]     rsData;
    logic [DATA_W-1:0]     rtData;
    logic [DATA_W-1:0]     immExt;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [5:0]            funct;
  } idEx_t;

  idEx_t exQ;
  idEx_t loadVal;

  // Only a definite 1 counts; X/Z from the decoder's don't-care outputs become 0.
  function automatic logic cleanBit(input logic b);
    return (b === 1'b1) ? 1'b1 : 1'b0;
  endfunction

  // Sanitised image of the decode stage, used on a normal load.
  always_comb begin
    loadVal          = '0;
    loadVal.valid    = 1'b1;
    loadVal.regWrite = cleanBit(id_reg_write);
    // reg_dst/mem_to_reg only matter for instructions that write back.
    loadVal.regDst   = loadVal.regWrite & cleanBit(id_reg_dst);
    loadVal.memToReg = loadVal.regWrite & cleanBit(id_mem_to_reg);
    loadVal.aluSrc   = cleanBit(id_alu_src);
    loadVal.memRead  = cleanBit(id_mem_read);
    loadVal.memWrite = cleanBit(id_mem_write);
    loadVal.branch   = cleanBit(id_branch);
    loadVal.aluOp    = {cleanBit(id_alu_op[1]), cleanBit(id_alu_op[0])};
    loadVal.pcPlus4  = id_pc_plus4;
    loadVal.rsData   = id_rs_data;
    loadVal.rtData   = id_rt_data;
    loadVal.immExt   = id_imm_ext;
    loadVal.rs       = id_rs;
    loadVal.rt       = id_rt;
    loadVal.rd       = id_rd;
    loadVal.funct    = id_funct;
  end

  // Pipeline register: flush > stall > load; an invalid ID slot loads a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exQ <= '0;
    end else if (flush) begin
      exQ <= '0;
    end else if (!stall) begin
      exQ <= id_valid ? loadVal : '0;
    end
  end

  assign ex_valid      = exQ.valid;
  assign ex_reg_dst    = exQ.regDst;
  assign ex_alu_src    = exQ.aluSrc;
  assign ex_mem_to_reg = exQ.memToReg;
  assign ex_reg_write  = exQ.regWrite;
  assign ex_mem_read   = exQ.memRead;
  assign ex_mem_write  = exQ.memWrite;
  assign ex_branch     = exQ.branch;
  assign ex_alu_op     = exQ.aluOp;
  assign ex_pc_plus4   = exQ.pcPlus4;
  assign ex_rs_data    = exQ.rsData;
  assign ex_rt_data    = exQ.rtData;
  assign ex_imm_ext    = exQ.immExt;
  assign ex_rs         = exQ.rs;
  assign ex_rt         = exQ.rt;
  assign ex_rd         = exQ.rd;
  assign ex_funct      = exQ.funct;

  // Load in EX whose destination (rt, never $0) is a source of the ID instruction.
  assign load_use_hazard = exQ.valid & exQ.memRead & exQ.regWrite
                         & (exQ.rt != '0)
                         & ((exQ.rt == id_rs) | (exQ.rt == id_rt));

endmodule
